// File: rtl/memisland_preload_arbiter.sv
// memisland_preload_arbiter
// Arbitrates narrow port 1 of the memory island between normal host traffic
// and a lock-based preload engine that streams aligned word writes. Ownership
// only changes hands once every in-flight request has been answered, so each
// read response always goes back to the requester that issued it.

module memisland_preload_arbiter #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    // Host port
    input  logic                     host_req_i,
    output logic                     host_gnt_o,
    input  logic [AddrWidth-1:0]     host_addr_i,
    input  logic                     host_we_i,
    input  logic [DataWidth-1:0]     host_wdata_i,
    input  logic [DataWidth/8-1:0]   host_strb_i,
    output logic                     host_rvalid_o,
    output logic [DataWidth-1:0]     host_rdata_o,

    // Preload port
    input  logic                     pl_lock_req_i,
    output logic                     pl_lock_gnt_o,
    input  logic                     pl_valid_i,
    output logic                     pl_ready_o,
    input  logic [AddrWidth-1:0]     pl_addr_i,
    input  logic [DataWidth-1:0]     pl_data_i,
    output logic [31:0]              pl_count_o,
    output logic                     pl_err_o,

    // Memory island port
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    output logic [AddrWidth-1:0]     mem_addr_o,
    output logic                     mem_we_o,
    output logic [DataWidth-1:0]     mem_wdata_o,
    output logic [DataWidth/8-1:0]   mem_strb_o,
    input  logic                     mem_rvalid_i,
    input  logic [DataWidth-1:0]     mem_rdata_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned CntWidth  = $clog2(MaxOutstanding + 1);

    localparam logic [CntWidth-1:0]  OutstMax   = CntWidth'(MaxOutstanding);
    localparam logic [CntWidth-1:0]  OutstZero  = {CntWidth{1'b0}};
    localparam logic [CntWidth-1:0]  OutstOne   = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [AddrWidth-1:0] OffsetMask = AddrWidth'(StrbWidth - 1);
    localparam logic [31:0]          CountMax   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_HOST    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_PRELOAD = 2'd2,
        ST_FINISH  = 2'd3
    } state_e;

    // Clear the byte-offset bits so the beat lands on its containing word.
    function automatic logic [AddrWidth-1:0] align_addr(input logic [AddrWidth-1:0] addr);
        return addr & ~OffsetMask;
    endfunction

    // A beat is misaligned when any byte-offset bit is set.
    function automatic logic is_misaligned(input logic [AddrWidth-1:0] addr);
        return |(addr & OffsetMask);
    endfunction

    state_e                state_r;
    logic [CntWidth-1:0]   outst_r;
    logic                  lock_gnt_r;
    logic [31:0]           pl_count_r;
    logic                  pl_err_r;

    logic                  outst_full_s;
    logic                  outst_zero_s;
    logic                  mem_fire_s;
    logic                  beat_fire_s;
    logic                  enter_preload_s;

    assign outst_full_s    = (outst_r == OutstMax);
    assign outst_zero_s    = (outst_r == OutstZero);
    assign mem_fire_s      = mem_req_o & mem_gnt_i;
    assign beat_fire_s     = pl_valid_i & pl_ready_o;
    assign enter_preload_s = (state_r == ST_DRAIN) & pl_lock_req_i & outst_zero_s;

    assign pl_lock_gnt_o = lock_gnt_r;
    assign pl_count_o    = pl_count_r;
    assign pl_err_o      = pl_err_r;

    // Steer the memory port and both requester ports according to the owner.
    always_comb begin
        mem_req_o     = 1'b0;
        mem_addr_o    = {AddrWidth{1'b0}};
        mem_we_o      = 1'b0;
        mem_wdata_o   = {DataWidth{1'b0}};
        mem_strb_o    = {StrbWidth{1'b0}};
        host_gnt_o    = 1'b0;
        host_rvalid_o = 1'b0;
        host_rdata_o  = {DataWidth{1'b0}};
        pl_ready_o    = 1'b0;

        case (state_r)
            ST_HOST: begin
                // Zero-latency pass-through, throttled only by the outstanding limit.
                mem_req_o     = host_req_i & ~outst_full_s;
                mem_addr_o    = host_addr_i;
                mem_we_o      = host_we_i;
                mem_wdata_o   = host_wdata_i;
                mem_strb_o    = host_strb_i;
                host_gnt_o    = mem_gnt_i & ~outst_full_s;
                host_rvalid_o = mem_rvalid_i;
                host_rdata_o  = mem_rdata_i;
            end
            ST_DRAIN: begin
                // No new requests; responses still belong to the host.
                host_rvalid_o = mem_rvalid_i;
                host_rdata_o  = mem_rdata_i;
            end
            ST_PRELOAD: begin
                // Full-word writes only; preload write responses are swallowed.
                mem_req_o   = pl_valid_i & pl_lock_req_i & ~outst_full_s;
                mem_addr_o  = align_addr(pl_addr_i);
                mem_we_o    = 1'b1;
                mem_wdata_o = pl_data_i;
                mem_strb_o  = {StrbWidth{1'b1}};
                pl_ready_o  = mem_gnt_i & pl_lock_req_i & ~outst_full_s;
            end
            ST_FINISH: begin
                // Port idle while the last preload responses are dropped.
                mem_req_o = 1'b0;
            end
            default: begin
                mem_req_o = 1'b0;
            end
        endcase
    end

    // Track granted-but-unanswered requests; grant and response together hold.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_r <= OutstZero;
        end else if (mem_fire_s && !mem_rvalid_i && !outst_full_s) begin
            outst_r <= outst_r + OutstOne;
        end else if (!mem_fire_s && mem_rvalid_i && !outst_zero_s) begin
            outst_r <= outst_r - OutstOne;
        end else begin
            outst_r <= outst_r;
        end
    end

    // Ownership sequencer; the lock grant is registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_HOST;
            lock_gnt_r <= 1'b0;
        end else begin
            case (state_r)
                ST_HOST: begin
                    lock_gnt_r <= 1'b0;
                    if (pl_lock_req_i) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_HOST;
                    end
                end
                ST_DRAIN: begin
                    if (!pl_lock_req_i) begin
                        state_r    <= ST_HOST;
                        lock_gnt_r <= 1'b0;
                    end else if (outst_zero_s) begin
                        state_r    <= ST_PRELOAD;
                        lock_gnt_r <= 1'b1;
                    end else begin
                        state_r    <= ST_DRAIN;
                        lock_gnt_r <= 1'b0;
                    end
                end
                ST_PRELOAD: begin
                    if (!pl_lock_req_i) begin
                        state_r    <= ST_FINISH;
                        lock_gnt_r <= 1'b0;
                    end else begin
                        state_r    <= ST_PRELOAD;
                        lock_gnt_r <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    lock_gnt_r <= 1'b0;
                    if (outst_zero_s) begin
                        state_r <= ST_HOST;
                    end else begin
                        state_r <= ST_FINISH;
                    end
                end
                default: begin
                    state_r    <= ST_HOST;
                    lock_gnt_r <= 1'b0;
                end
            endcase
        end
    end

    // Per-session word count and sticky misalignment flag, reset at each new grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pl_count_r <= 32'd0;
            pl_err_r   <= 1'b0;
        end else if (enter_preload_s) begin
            pl_count_r <= 32'd0;
            pl_err_r   <= 1'b0;
        end else if (beat_fire_s) begin
            if (pl_count_r != CountMax) begin
                pl_count_r <= pl_count_r + 32'd1;
            end else begin
                pl_count_r <= pl_count_r;
            end
            pl_err_r <= pl_err_r | is_misaligned(pl_addr_i);
        end else begin
            pl_count_r <= pl_count_r;
            pl_err_r   <= pl_err_r;
        end
    end

endmodule

// File: tb/tb_memisland_preload_arbiter.sv
// Directed bench for memisland_preload_arbiter. The bench plays the memory
// island by hand: it drives mem_gnt_i / mem_rvalid_i / mem_rdata_i cycle by
// cycle and checks the arbiter outputs against hand-computed values.

module tb_memisland_preload_arbiter;

    logic        clk;
    logic        rst_i;
    logic        host_req_i;
    logic        host_gnt_o;
    logic [31:0] host_addr_i;
    logic        host_we_i;
    logic [31:0] host_wdata_i;
    logic [3:0]  host_strb_i;
    logic        host_rvalid_o;
    logic [31:0] host_rdata_o;
    logic        pl_lock_req_i;
    logic        pl_lock_gnt_o;
    logic        pl_valid_i;
    logic        pl_ready_o;
    logic [31:0] pl_addr_i;
    logic [31:0] pl_data_i;
    logic [31:0] pl_count_o;
    logic        pl_err_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_strb_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int n_compared   = 0;
    int n_mismatched = 0;

    memisland_preload_arbiter #(
        .AddrWidth      (32),
        .DataWidth      (32),
        .MaxOutstanding (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .host_req_i    (host_req_i),
        .host_gnt_o    (host_gnt_o),
        .host_addr_i   (host_addr_i),
        .host_we_i     (host_we_i),
        .host_wdata_i  (host_wdata_i),
        .host_strb_i   (host_strb_i),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .pl_lock_req_i (pl_lock_req_i),
        .pl_lock_gnt_o (pl_lock_gnt_o),
        .pl_valid_i    (pl_valid_i),
        .pl_ready_o    (pl_ready_o),
        .pl_addr_i     (pl_addr_i),
        .pl_data_i     (pl_data_i),
        .pl_count_o    (pl_count_o),
        .pl_err_o      (pl_err_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_addr_o    (mem_addr_o),
        .mem_we_o      (mem_we_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_strb_o    (mem_strb_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        host_req_i = 1'b0; host_addr_i = 32'd0; host_we_i = 1'b0;
        host_wdata_i = 32'd0; host_strb_i = 4'd0;
        pl_lock_req_i = 1'b0; pl_valid_i = 1'b0; pl_addr_i = 32'd0; pl_data_i = 32'd0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0;
        tick(); tick();
        rst_i = 1'b0;
        tick();

        // ---- Reset state: all inputs 0 -> all outputs 0
        settle();
        chk("rst_lock_gnt", pl_lock_gnt_o, 0);
        chk("rst_count",    pl_count_o,    0);
        chk("rst_err",      pl_err_o,      0);
        chk("rst_mem_req",  mem_req_o,     0);
        chk("rst_mem_addr", mem_addr_o,    0);
        chk("rst_mem_we",   mem_we_o,      0);
        chk("rst_mem_strb", mem_strb_o,    0);
        chk("rst_host_gnt", host_gnt_o,    0);
        chk("rst_host_rv",  host_rvalid_o, 0);
        chk("rst_pl_ready", pl_ready_o,    0);

        // ---- Host read of 0x1000, same-cycle pass-through
        host_req_i = 1'b1; host_addr_i = 32'h1000; host_we_i = 1'b0;
        host_strb_i = 4'hF; mem_gnt_i = 1'b1;
        settle();
        chk("hrd_mem_req",  mem_req_o,  1);
        chk("hrd_mem_addr", mem_addr_o, 32'h1000);
        chk("hrd_mem_we",   mem_we_o,   0);
        chk("hrd_host_gnt", host_gnt_o, 1);
        tick();
        host_req_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        settle();
        chk("hrd_rvalid", host_rvalid_o, 1);
        chk("hrd_rdata",  host_rdata_o,  32'hDEADBEEF);
        tick();
        mem_rvalid_i = 1'b0;

        // ---- Host write with partial strobe; its response is forwarded
        host_req_i = 1'b1; host_addr_i = 32'h1004; host_we_i = 1'b1;
        host_wdata_i = 32'h12345678; host_strb_i = 4'h3; mem_gnt_i = 1'b1;
        settle();
        chk("hwr_mem_we",    mem_we_o,    1);
        chk("hwr_mem_wdata", mem_wdata_o, 32'h12345678);
        chk("hwr_mem_strb",  mem_strb_o,  4'h3);
        tick();
        host_req_i = 1'b0; host_we_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        settle();
        chk("hwr_rvalid", host_rvalid_o, 1);
        tick();
        mem_rvalid_i = 1'b0;

        // ---- Host outstanding limit: 4 grants, 5th request blocked
        for (int i = 0; i < 4; i++) begin
            host_req_i = 1'b1; host_addr_i = 32'h2000 + 32'(4 * i); mem_gnt_i = 1'b1;
            settle();
            chk("hlim_gnt", host_gnt_o, 1);
            tick();
        end
        settle();
        chk("hlim_full_req", mem_req_o,  0);
        chk("hlim_full_gnt", host_gnt_o, 0);
        host_req_i = 1'b0; mem_gnt_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11110000 + 32'(k);
            settle();
            chk("hlim_rdata", host_rdata_o, 32'h11110000 + 32'(k));
            tick();
        end
        mem_rvalid_i = 1'b0;

        // ---- Drain before grant: 3 host reads in flight, then lock request
        for (int i = 0; i < 3; i++) begin
            host_req_i = 1'b1; host_addr_i = 32'h3000 + 32'(4 * i); mem_gnt_i = 1'b1;
            tick();
        end
        host_req_i = 1'b0; mem_gnt_i = 1'b0; pl_lock_req_i = 1'b1;
        settle();
        chk("drn_gnt_t0", pl_lock_gnt_o, 0);
        tick();
        host_req_i = 1'b1; mem_gnt_i = 1'b1;
        settle();
        chk("drn_block_req", mem_req_o,  0);
        chk("drn_block_gnt", host_gnt_o, 0);
        host_req_i = 1'b0; mem_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA0000000 + 32'(k);
            settle();
            chk("drn_rvalid",   host_rvalid_o, 1);
            chk("drn_rdata",    host_rdata_o,  32'hA0000000 + 32'(k));
            chk("drn_gnt_wait", pl_lock_gnt_o, 0);
            tick();
        end
        mem_rvalid_i = 1'b0;
        tick();
        settle();
        chk("drn_gnt",   pl_lock_gnt_o, 1);
        chk("drn_count", pl_count_o,    0);
        chk("drn_err",   pl_err_o,      0);

        // ---- Preload burst: 16 beats 0x8000..0x803C, gnt held high
        mem_gnt_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pl_valid_i = 1'b1; pl_addr_i = 32'h8000 + 32'(4 * i);
            pl_data_i = 32'hB0000000 + 32'(i);
            mem_rvalid_i = (i > 0);
            settle();
            chk("pb_count",  pl_count_o,    32'(i));
            chk("pb_req",    mem_req_o,     1);
            chk("pb_addr",   mem_addr_o,    32'h8000 + 32'(4 * i));
            chk("pb_wdata",  mem_wdata_o,   32'hB0000000 + 32'(i));
            chk("pb_we",     mem_we_o,      1);
            chk("pb_strb",   mem_strb_o,    4'hF);
            chk("pb_ready",  pl_ready_o,    1);
            chk("pb_hrv",    host_rvalid_o, 0);
            tick();
        end
        pl_valid_i = 1'b0; mem_rvalid_i = 1'b1;
        settle();
        chk("pb_count16", pl_count_o,    32'd16);
        chk("pb_hrv_end", host_rvalid_o, 0);
        tick();
        mem_rvalid_i = 1'b0;

        // ---- Backpressure: 4 accepts, then stall until a response arrives
        for (int i = 0; i < 4; i++) begin
            pl_valid_i = 1'b1; pl_addr_i = 32'h9000 + 32'(4 * i);
            settle();
            chk("bp_accept", pl_ready_o, 1);
            tick();
        end
        pl_addr_i = 32'h9010;
        for (int s = 0; s < 8; s++) begin
            settle();
            chk("bp_stall_ready", pl_ready_o, 0);
            chk("bp_stall_req",   mem_req_o,  0);
            tick();
        end
        mem_rvalid_i = 1'b1;
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk("bp_resume_ready", pl_ready_o, 1);
        chk("bp_resume_addr",  mem_addr_o, 32'h9010);
        tick();
        pl_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i = 1'b1;
            settle();
            chk("bp_drop_rv", host_rvalid_o, 0);
            tick();
        end
        mem_rvalid_i = 1'b0;
        settle();
        chk("bp_count", pl_count_o, 32'd21);

        // ---- Misaligned beat at 0x8002 lands on 0x8000 and flags pl_err
        pl_valid_i = 1'b1; pl_addr_i = 32'h8002; pl_data_i = 32'hCAFE0002;
        settle();
        chk("mis_addr",  mem_addr_o, 32'h8000);
        chk("mis_ready", pl_ready_o, 1);
        chk("mis_err0",  pl_err_o,   0);
        tick();

        // ---- Release with one write still outstanding
        pl_lock_req_i = 1'b0; pl_addr_i = 32'h8004;
        settle();
        chk("rel_ready", pl_ready_o,    0);
        chk("rel_req",   mem_req_o,     0);
        chk("rel_err",   pl_err_o,      1);
        chk("rel_count", pl_count_o,    32'd22);
        tick();
        pl_valid_i = 1'b0; host_req_i = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
        settle();
        chk("fin_gnt",   pl_lock_gnt_o, 0);
        chk("fin_req",   mem_req_o,     0);
        chk("fin_hgnt",  host_gnt_o,    0);
        chk("fin_hrv",   host_rvalid_o, 0);
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        chk("fin_hgnt2", host_gnt_o, 0);
        tick();
        mem_gnt_i = 1'b0;
        settle();
        chk("host_back_req", mem_req_o,  1);
        chk("host_back_err", pl_err_o,   1);
        chk("host_back_cnt", pl_count_o, 32'd22);
        host_req_i = 1'b0;

        // ---- Abort in DRAIN: back to HOST, count unchanged
        pl_lock_req_i = 1'b1;
        tick();
        pl_lock_req_i = 1'b0;
        settle();
        chk("abt_gnt", pl_lock_gnt_o, 0);
        tick();
        host_req_i = 1'b1;
        settle();
        chk("abt_host_req", mem_req_o,     1);
        chk("abt_count",    pl_count_o,    32'd22);
        chk("abt_err",      pl_err_o,      1);
        chk("abt_gnt2",     pl_lock_gnt_o, 0);
        host_req_i = 1'b0;

        // ---- Idle acquisition: request at t, DRAIN at t+1, grant at t+2
        pl_lock_req_i = 1'b1;
        settle();
        chk("acq_t0", pl_lock_gnt_o, 0);
        tick();
        settle();
        chk("acq_t1", pl_lock_gnt_o, 0);
        tick();
        settle();
        chk("acq_t2",    pl_lock_gnt_o, 1);
        chk("acq_err",   pl_err_o,      0);
        chk("acq_count", pl_count_o,    0);

        // ---- Reset during PRELOAD
        pl_valid_i = 1'b1; pl_addr_i = 32'hA000; mem_gnt_i = 1'b1;
        settle();
        chk("rp_ready", pl_ready_o, 1);
        tick();
        pl_valid_i = 1'b0; mem_gnt_i = 1'b0;
        settle();
        chk("rp_count1", pl_count_o, 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; pl_lock_req_i = 1'b0; host_req_i = 1'b1;
        settle();
        chk("rp_gnt",      pl_lock_gnt_o, 0);
        chk("rp_count",    pl_count_o,    0);
        chk("rp_err",      pl_err_o,      0);
        chk("rp_host_req", mem_req_o,     1);
        host_req_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
